accel_host_bridge: RTL and testbench

Parametrised host-side front end for the lane-detection accelerator. It sits between the memory-mapped host bus and the core datapath. It decodes host writes into an in-order pixel stream for the input FIFO, serves output-map reads from the result BRAM with fixed latency, and owns soft reset, busy/done status and a frame counter. Compared with the fixed-size front end, it adds sticky error flags, write-order checking, a frame counter and an optional done interrupt.

---
 rtl/accel_host_pkg.sv | 44 ++++
 rtl/accel_soft_reset_gen.sv | 29 ++
 rtl/accel_host_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_accel_host_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_host_pkg.sv
// Shared definitions for the lane-detection host bridge: register map,
// status/control bit positions, read-source select and region base helpers.
package accel_host_pkg;

   localparam int unsigned REG_STATUS      = 0;
   localparam int unsigned REG_CONTROL     = 4;
   localparam int unsigned REG_FRAME_COUNT = 8;
   localparam int unsigned REG_IRQ         = 12;

   localparam int unsigned ST_DONE      = 0;
   localparam int unsigned ST_BUSY      = 1;
   localparam int unsigned ST_OVERFLOW  = 2;
   localparam int unsigned ST_ORDER_ERR = 3;

   localparam int unsigned CTL_SOFT_RST = 0;
   localparam int unsigned CTL_CLEAR    = 1;

   localparam int unsigned IRQ_EN_BIT   = 0;
   localparam int unsigned IRQ_PEND_BIT = 1;

   // Field order matches the STATUS register layout, bit0 = done.
   typedef struct packed {
      logic order_err;
      logic overflow;
      logic busy;
      logic done;
   } status_t;

   typedef enum logic [1:0] {
      RD_ZERO,
      RD_BRAM,
      RD_REG
   } rd_src_e;

   function automatic int unsigned out_base(int unsigned width, int unsigned height);
      return width * height * 4;
   endfunction

   function automatic int unsigned ctrl_base(int unsigned width, int unsigned height,
                                             int unsigned out_bytes);
      return out_base(width, height) + out_bytes;
   endfunction

endpackage

// File: rtl/accel_soft_reset_gen.sv
// Soft-reset pulse generator: holds soft_rst_n low for RESET_CYCLES cycles
// after start; a start seen while the pulse is running does not extend it.
module accel_soft_reset_gen #(
   parameter int unsigned RESET_CYCLES = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic soft_rst_n,
   output logic active
);

   localparam int unsigned CW = $clog2(RESET_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (cnt != '0)
         cnt <= cnt - CW'(1);
      else if (start)
         cnt <= CW'(RESET_CYCLES);
   end

   assign active     = (cnt != '0);
   assign soft_rst_n = rst_n & ~active;

endmodule

// File: rtl/accel_host_bridge.sv
// Host-bus front end for the lane-detection accelerator: in-order pixel stream,
// output-map reads, status/control, frame counter. Define ACCEL_HOST_IRQ_EN for the done interrupt.
module accel_host_bridge
   import accel_host_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 20,
   parameter int unsigned IN_WIDTH     = 512,
   parameter int unsigned IN_HEIGHT    = 256,
   parameter int unsigned IN_CHANNELS  = 3,
   parameter int unsigned PIXEL_BITS   = 7,
   parameter int unsigned OUT_BYTES    = 2048,
   parameter int unsigned RESET_CYCLES = 15
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                host_wr_en,
   input  logic [ADDR_WIDTH-1:0]               host_wr_addr,
   input  logic [31:0]                         host_wr_data,
   input  logic [3:0]                          host_wr_strobe,
   input  logic                                host_rd_en,
   input  logic [ADDR_WIDTH-1:0]               host_rd_addr,
   output logic [31:0]                         host_rd_data,
   output logic                                host_rd_valid,
   output logic [IN_CHANNELS*PIXEL_BITS-1:0]   pix_data,
   output logic                                pix_valid,
   input  logic                                pix_full,
   output logic                                first_pixel,
   input  logic                                core_done,
   output logic [$clog2(OUT_BYTES/4)-1:0]      bram_rd_addr,
   output logic                                bram_rd_en,
   input  logic [31:0]                         bram_rd_data,
   output logic                                soft_rst_n,
   output logic                                busy,
   output logic                                done,
   output logic                                irq
);

   localparam int unsigned NPIX      = IN_WIDTH * IN_HEIGHT;
   localparam int unsigned IDX_W     = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int unsigned PIX_W     = IN_CHANNELS * PIXEL_BITS;
   localparam int unsigned BRAM_AW   = $clog2(OUT_BYTES / 4);
   localparam int unsigned OUT_BASE  = out_base(IN_WIDTH, IN_HEIGHT);
   localparam int unsigned CTRL_BASE = ctrl_base(IN_WIDTH, IN_HEIGHT, OUT_BYTES);

   logic             srst_start, srst_active;
   logic [31:0]      wa, ra;
   logic             wr_ok, pix_acc, pix_match, pix_in_order, pix_push, pix_ooo;
   logic             frame_start, ctrl_wr, clr_wr, rd_in_out;
   logic [IDX_W-1:0] widx, exp_idx_q;
   logic [PIX_W-1:0] pix_trunc;
   status_t          status_q, status_d;
   logic [15:0]      frame_cnt_q;
   rd_src_e          rd_src_q, rd_src_d;
   logic [31:0]      rd_reg_q, rd_reg_d, irq_rd_val;
   logic             rd_valid_q;
   logic             unused_bits;

   accel_soft_reset_gen #(.RESET_CYCLES(RESET_CYCLES)) u_soft_reset (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (srst_start),
      .soft_rst_n (soft_rst_n),
      .active     (srst_active)
   );

   assign wa    = 32'(host_wr_addr);
   assign ra    = 32'(host_rd_addr);
   assign wr_ok = host_wr_en & ~srst_active;
   assign widx  = wa[IDX_W+1:2];

   assign pix_acc      = wr_ok && (wa < NPIX * 4) && (wa[1:0] == 2'b00)
                         && (&host_wr_strobe[IN_CHANNELS-1:0]);
   assign pix_match    = (widx == exp_idx_q);
   assign pix_in_order = pix_acc & pix_match;
   assign pix_push     = pix_in_order & ~pix_full;
   assign pix_ooo      = pix_acc & ~pix_match;
   assign frame_start  = pix_in_order && (widx == '0);

   assign ctrl_wr    = wr_ok && (wa == CTRL_BASE + REG_CONTROL) && host_wr_strobe[0];
   assign srst_start = ctrl_wr & host_wr_data[CTL_SOFT_RST];
   assign clr_wr     = ctrl_wr & host_wr_data[CTL_CLEAR];

   assign unused_bits = ^{host_wr_data, host_wr_strobe};

   // Keep the top PIXEL_BITS of each channel byte.
   always_comb begin
      pix_trunc = '0;
      for (int unsigned c = 0; c < IN_CHANNELS; c++)
         pix_trunc[c*PIXEL_BITS +: PIXEL_BITS] = host_wr_data[c*8 + (8 - PIXEL_BITS) +: PIXEL_BITS];
   end

   // core_done is applied last so it wins over a same-cycle clear or frame start.
   always_comb begin
      status_d = status_q;
      if (clr_wr) begin
         status_d.done      = 1'b0;
         status_d.overflow  = 1'b0;
         status_d.order_err = 1'b0;
      end
      if (pix_ooo)
         status_d.order_err = 1'b1;
      if (pix_in_order && pix_full)
         status_d.overflow = 1'b1;
      if (frame_start) begin
         status_d.busy = 1'b1;
         status_d.done = 1'b0;
      end
      if (core_done) begin
         status_d.done = 1'b1;
         if (!frame_start)
            status_d.busy = 1'b0;
      end
   end

   assign rd_in_out    = (ra >= OUT_BASE) && (ra < CTRL_BASE);
   assign bram_rd_en   = host_rd_en & rd_in_out;
   assign bram_rd_addr = BRAM_AW'((ra - OUT_BASE) >> 2);

   always_comb begin
      rd_src_d = RD_ZERO;
      rd_reg_d = '0;
      if (host_rd_en) begin
         if (rd_in_out) begin
            rd_src_d = RD_BRAM;
         end else if (ra == CTRL_BASE + REG_STATUS) begin
            rd_src_d = RD_REG;
            rd_reg_d = 32'(status_q);
         end else if (ra == CTRL_BASE + REG_FRAME_COUNT) begin
            rd_src_d = RD_REG;
            rd_reg_d = 32'(frame_cnt_q);
         end else if (ra == CTRL_BASE + REG_IRQ) begin
            rd_src_d = RD_REG;
            rd_reg_d = irq_rd_val;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_idx_q   <= '0;
         status_q    <= '0;
         frame_cnt_q <= '0;
         pix_valid   <= 1'b0;
         first_pixel <= 1'b0;
         pix_data    <= '0;
         rd_valid_q  <= 1'b0;
         rd_src_q    <= RD_ZERO;
         rd_reg_q    <= '0;
      end else if (srst_active) begin
         exp_idx_q   <= '0;
         status_q    <= '0;
         frame_cnt_q <= '0;
         pix_valid   <= 1'b0;
         first_pixel <= 1'b0;
         pix_data    <= '0;
         rd_valid_q  <= 1'b0;
         rd_src_q    <= RD_ZERO;
         rd_reg_q    <= '0;
      end else begin
         status_q    <= status_d;
         pix_valid   <= pix_push;
         first_pixel <= frame_start;
         if (pix_push)
            pix_data <= pix_trunc;
         if (pix_in_order)
            exp_idx_q <= (exp_idx_q == IDX_W'(NPIX - 1)) ? '0 : exp_idx_q + IDX_W'(1);
         if (core_done)
            frame_cnt_q <= frame_cnt_q + 16'd1;
         rd_valid_q <= host_rd_en;
         rd_src_q   <= rd_src_d;
         rd_reg_q   <= rd_reg_d;
      end
   end

   assign host_rd_valid = rd_valid_q;
   assign host_rd_data  = (rd_src_q == RD_BRAM) ? bram_rd_data : rd_reg_q;
   assign busy          = status_q.busy;
   assign done          = status_q.done;

`ifdef ACCEL_HOST_IRQ_EN
   logic irq_wr, irq_en_q, irq_pend_q, irq_en_d, irq_pend_d, irq_q;

   assign irq_wr = wr_ok && (wa == CTRL_BASE + REG_IRQ) && host_wr_strobe[0];

   always_comb begin
      irq_en_d   = irq_en_q;
      irq_pend_d = irq_pend_q;
      if (irq_wr) begin
         irq_en_d = host_wr_data[IRQ_EN_BIT];
         if (host_wr_data[IRQ_PEND_BIT])
            irq_pend_d = 1'b0;
      end
      if (core_done)
         irq_pend_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en_q   <= 1'b0;
         irq_pend_q <= 1'b0;
         irq_q      <= 1'b0;
      end else if (srst_active) begin
         irq_en_q   <= 1'b0;
         irq_pend_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         irq_en_q   <= irq_en_d;
         irq_pend_q <= irq_pend_d;
         irq_q      <= irq_en_d & irq_pend_d;
      end
   end

   assign irq        = irq_q;
   assign irq_rd_val = {30'd0, irq_pend_q, irq_en_q};
`else
   assign irq        = 1'b0;
   assign irq_rd_val = '0;
`endif

endmodule

// File: tb/tb_accel_host_bridge.sv
// Scoreboard bench for accel_host_bridge on a small 8x4 frame: randomized host
// traffic checked against a register-level behavioural model of the bridge.
module tb_accel_host_bridge;

   localparam int AW = 10, W = 8, H = 4, CH = 3, PB = 7, OB = 64, RC = 7;
   localparam int NPIX = W * H;
   localparam int OUT_BASE = NPIX * 4;
   localparam int CTRL_BASE = OUT_BASE + OB;
   localparam int NWORDS = OB / 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              host_wr_en = 1'b0;
   logic [AW-1:0]     host_wr_addr = '0;
   logic [31:0]       host_wr_data = '0;
   logic [3:0]        host_wr_strobe = '0;
   logic              host_rd_en = 1'b0;
   logic [AW-1:0]     host_rd_addr = '0;
   logic [31:0]       host_rd_data;
   logic              host_rd_valid;
   logic [CH*PB-1:0]  pix_data;
   logic              pix_valid;
   logic              pix_full = 1'b0;
   logic              first_pixel;
   logic              core_done = 1'b0;
   logic [3:0]        bram_rd_addr;
   logic              bram_rd_en;
   logic [31:0]       bram_rd_data;
   logic              soft_rst_n, busy, done, irq;

   accel_host_bridge #(
      .ADDR_WIDTH(AW), .IN_WIDTH(W), .IN_HEIGHT(H), .IN_CHANNELS(CH),
      .PIXEL_BITS(PB), .OUT_BYTES(OB), .RESET_CYCLES(RC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr),
      .host_wr_data(host_wr_data), .host_wr_strobe(host_wr_strobe),
      .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr),
      .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_full(pix_full),
      .first_pixel(first_pixel), .core_done(core_done),
      .bram_rd_addr(bram_rd_addr), .bram_rd_en(bram_rd_en), .bram_rd_data(bram_rd_data),
      .soft_rst_n(soft_rst_n), .busy(busy), .done(done), .irq(irq)
   );

   always #5 clk = ~clk;

   logic [31:0] bram_mem [NWORDS];
   always @(posedge clk) if (bram_rd_en) bram_rd_data <= bram_mem[bram_rd_addr];

   typedef struct {
      logic [CH*PB-1:0] data;
      logic             first;
   } pix_t;

   pix_t        pix_q[$];
   logic [31:0] rd_q[$];
   int          nvec = 0, nfail = 0;

   int          exp_idx = 0;
   bit          m_busy, m_done, m_ovf, m_oerr, m_en, m_pend;
   logic [15:0] m_fc = '0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic [CH*PB-1:0] trunc(logic [31:0] d);
      logic [CH*PB-1:0] r = '0;
      for (int c = 0; c < CH; c++) begin
         int b = int'((d >> (8 * c)) & 32'hFF);
         r |= (CH*PB)'(b >> (8 - PB)) << (PB * c);
      end
      return r;
   endfunction

   function automatic bit m_irq();
`ifdef ACCEL_HOST_IRQ_EN
      return m_en & m_pend;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] exp_read(int a);
      if (a >= OUT_BASE && a < CTRL_BASE) return bram_mem[(a - OUT_BASE) / 4];
      if (a == CTRL_BASE) return {28'd0, m_oerr, m_ovf, m_busy, m_done};
      if (a == CTRL_BASE + 8) return {16'd0, m_fc};
`ifdef ACCEL_HOST_IRQ_EN
      if (a == CTRL_BASE + 12) return {30'd0, m_pend, m_en};
`endif
      return 32'd0;
   endfunction

   function automatic void model_reset();
      exp_idx = 0;
      {m_busy, m_done, m_ovf, m_oerr, m_en, m_pend} = '0;
      m_fc = '0;
   endfunction

   function automatic void done_model(bit start_same_cycle);
      m_done = 1'b1;
      m_busy = start_same_cycle;
      m_fc   = m_fc + 16'd1;
      m_pend = 1'b1;
   endfunction

   task automatic chk_flags();
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("irq", irq, m_irq());
   endtask

   task automatic pix_wr(int addr, logic [31:0] d, logic [3:0] s, bit full, bit with_done);
      bit started = 1'b0;
      @(negedge clk);
      host_wr_en = 1'b1; host_wr_addr = AW'(addr); host_wr_data = d;
      host_wr_strobe = s; pix_full = full; core_done = with_done;
      if (addr < NPIX * 4 && addr % 4 == 0 && (&s[CH-1:0])) begin
         if (addr / 4 == exp_idx) begin
            if (full) m_ovf = 1'b1;
            else pix_q.push_back('{trunc(d), exp_idx == 0});
            if (exp_idx == 0) begin
               m_busy = 1'b1; m_done = 1'b0; started = 1'b1;
            end
            exp_idx = (exp_idx + 1) % NPIX;
         end else begin
            m_oerr = 1'b1;
         end
      end
      if (with_done) done_model(started);
      @(negedge clk);
      host_wr_en = 1'b0; pix_full = 1'b0; core_done = 1'b0;
   endtask

   task automatic reg_wr(int off, logic [31:0] d, logic [3:0] s, bit with_done);
      @(negedge clk);
      host_wr_en = 1'b1; host_wr_addr = AW'(CTRL_BASE + off);
      host_wr_data = d; host_wr_strobe = s; core_done = with_done;
      if (off == 4 && s[0] && d[1]) begin
         m_done = 1'b0; m_ovf = 1'b0; m_oerr = 1'b0;
      end
`ifdef ACCEL_HOST_IRQ_EN
      if (off == 12 && s[0]) begin
         m_en = d[0];
         if (d[1]) m_pend = 1'b0;
      end
`endif
      if (with_done) done_model(1'b0);
      @(negedge clk);
      host_wr_en = 1'b0; core_done = 1'b0;
   endtask

   task automatic core_pulse();
      @(negedge clk);
      core_done = 1'b1;
      done_model(1'b0);
      @(negedge clk);
      core_done = 1'b0;
   endtask

   task automatic rd(int a);
      bit in_out;
      @(negedge clk);
      host_rd_en = 1'b1; host_rd_addr = AW'(a);
      rd_q.push_back(exp_read(a));
      in_out = (a >= OUT_BASE && a < CTRL_BASE);
      #1;
      chk("bram_rd_en", bram_rd_en, in_out);
      if (in_out) chk("bram_rd_addr", bram_rd_addr, (a - OUT_BASE) / 4);
   endtask

   task automatic rd_idle();
      @(negedge clk);
      host_rd_en = 1'b0;
   endtask

   task automatic soft_reset();
      int cnt = 0;
      @(negedge clk);
      host_wr_en = 1'b1; host_wr_addr = AW'(CTRL_BASE + 4);
      host_wr_data = 32'h1; host_wr_strobe = 4'hF;
      model_reset();
      @(negedge clk);
      for (int i = 0; i < 60; i++) begin
         if (!soft_rst_n) cnt++;
         else break;
         if (i == 1) begin
            host_wr_en = 1'b1; host_wr_addr = AW'(CTRL_BASE + 4);
            host_wr_data = 32'h1; host_wr_strobe = 4'hF;
         end else if (i == 3) begin
            host_wr_en = 1'b1; host_wr_addr = '0;
            host_wr_data = 32'h00FF8040; host_wr_strobe = 4'hF;
         end else begin
            host_wr_en = 1'b0;
         end
         @(negedge clk);
      end
      host_wr_en = 1'b0;
      chk("soft_rst_len", cnt, RC);
   endtask

   // Monitor: pop expectations whenever the DUT presents a pixel or read data.
   initial begin
      pix_t e;
      logic [31:0] r;
      forever begin
         @(posedge clk);
         #1;
         if (pix_valid) begin
            if (pix_q.size() == 0) chk("pix_valid_unexpected", pix_valid, 1'b0);
            else begin
               e = pix_q.pop_front();
               chk("pix_data", pix_data, e.data);
               chk("first_pixel", first_pixel, e.first);
            end
         end else begin
            chk("first_pixel_stray", first_pixel, 1'b0);
         end
         if (host_rd_valid) begin
            if (rd_q.size() == 0) chk("rd_valid_unexpected", host_rd_valid, 1'b0);
            else begin
               r = rd_q.pop_front();
               chk("host_rd_data", host_rd_data, r);
            end
         end
      end
   end

   initial begin
      int op, a;
      logic [31:0] d;
      logic [3:0] s;

      for (int i = 0; i < NWORDS; i++) bram_mem[i] = $urandom;
      bram_mem[5] = 32'hA5A5_0001;
      model_reset();

      repeat (3) @(negedge clk);
      chk("rst_soft_rst_n", soft_rst_n, 1'b0);
      chk("rst_pix_valid", pix_valid, 1'b0);
      chk("rst_pix_data", pix_data, '0);
      chk("rst_rd_valid", host_rd_valid, 1'b0);
      chk("rst_rd_data", host_rd_data, 32'd0);
      chk_flags();
      rst_n = 1'b1;
      @(negedge clk);
      chk("soft_rst_n_released", soft_rst_n, 1'b1);

      for (int i = 0; i < 4; i++) pix_wr(i * 4, 32'h00FF8040, 4'hF, 1'b0, 1'b0);
      chk_flags();
      rd(CTRL_BASE); rd_idle();

      pix_wr(exp_idx * 4, $urandom, 4'hF, 1'b0, 1'b0);
      pix_wr(((exp_idx + 1) % NPIX) * 4, $urandom, 4'hF, 1'b0, 1'b0);
      rd(CTRL_BASE); rd_idle();
      reg_wr(4, 32'h2, 4'hF, 1'b0);
      rd(CTRL_BASE); rd_idle();

      pix_wr(exp_idx * 4, $urandom, 4'hF, 1'b1, 1'b0);
      rd(CTRL_BASE); rd_idle();

      reg_wr(12, 32'h1, 4'hF, 1'b0);
      core_pulse();
      chk_flags();
      rd(CTRL_BASE + 8); rd_idle();
      reg_wr(12, 32'h3, 4'hF, 1'b1);
      chk_flags();
      rd(CTRL_BASE + 12); rd_idle();
      reg_wr(12, 32'h2, 4'hF, 1'b0);
      chk_flags();
      reg_wr(4, 32'h2, 4'h1, 1'b1);
      chk_flags();

      rd(OUT_BASE + 20); rd(CTRL_BASE + 32'h40); rd(CTRL_BASE + 4); rd_idle();

      while (exp_idx != 0) pix_wr(exp_idx * 4, $urandom, 4'h7, 1'b0, 1'b0);
      pix_wr(0, $urandom, 4'hF, 1'b0, 1'b1);
      chk_flags();
      pix_wr(4, $urandom, 4'hF, 1'b0, 1'b0);
      soft_reset();
      chk_flags();
      rd(CTRL_BASE); rd(CTRL_BASE + 8); rd_idle();
      pix_wr(0, 32'h0012_3456, 4'hF, 1'b0, 1'b0);
      chk_flags();

      for (int it = 0; it < 400; it++) begin
         op = $urandom_range(0, 11);
         case (op)
            0, 1, 2, 3:
               pix_wr(exp_idx * 4, $urandom, $urandom_range(0, 1) ? 4'hF : 4'h7,
                      (exp_idx != 0) && ($urandom_range(0, 7) == 0), 1'b0);
            4: pix_wr(((exp_idx + 1 + $urandom_range(0, NPIX - 2)) % NPIX) * 4,
                      $urandom, 4'hF, 1'b0, 1'b0);
            5: begin
               if ($urandom_range(0, 1)) begin
                  pix_wr(exp_idx * 4 + $urandom_range(1, 3), $urandom, 4'hF, 1'b0, 1'b0);
               end else begin
                  s = 4'($urandom_range(0, 15));
                  if (&s[2:0]) s[$urandom_range(0, 2)] = 1'b0;
                  pix_wr(exp_idx * 4, $urandom, s, 1'b0, 1'b0);
               end
            end
            6: core_pulse();
            7: begin
               case ($urandom_range(0, 6))
                  0: a = CTRL_BASE;
                  1: a = CTRL_BASE + 4;
                  2: a = CTRL_BASE + 8;
                  3: a = CTRL_BASE + 12;
                  4: a = CTRL_BASE + 32'h40;
                  5: a = 4 * $urandom_range(0, NPIX - 1);
                  default: a = OUT_BASE + 4 * $urandom_range(0, NWORDS - 1);
               endcase
               rd(a); rd_idle();
            end
            8: begin
               rd(OUT_BASE + 4 * $urandom_range(0, NWORDS - 1));
               rd(CTRL_BASE + 4 * $urandom_range(0, 4));
               rd_idle();
            end
            9: begin
               d = $urandom; s = 4'($urandom_range(0, 15));
               if (s[0]) d[0] = 1'b0;
               reg_wr(4, d, s, $urandom_range(0, 3) == 0);
            end
            10: reg_wr(12, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                       $urandom_range(0, 3) == 0);
            default: reg_wr(4 * $urandom_range(0, 2) == 4 ? 0 : 8, $urandom, 4'hF, 1'b0);
         endcase
         chk_flags();
      end

      repeat (5) @(negedge clk);
      chk("pix_q_drained", pix_q.size(), 0);
      chk("rd_q_drained", rd_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
